// File: rtl/y86_seq_ctrl.sv
// -----------------------------------------------------------------------------
// y86_seq_ctrl
// Sequencing controller for the Y86-64 SEQ datapath. Owns the architectural PC,
// walks one stage per cycle (fetch, decode, execute, memory, writeback, PC
// update), waits on the data-memory ready handshake and produces the Y86
// status code. Supports free-run (run_i) and single-step (step_i) operation.
//
// Optional build macro: Y86_SEQ_CTRL_BRKPT_EN
//   Adds a PC breakpoint (bp_en_i, bp_addr_i, bp_hit_o). Undefined by default.
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        synchronous reset, active high (1 = reset)
//   run_i          level, execute instructions back-to-back
//   step_i         pulse, execute one instruction from IDLE when run_i=0
//   icode_i        icode from fetch
//   instr_valid_i  fetch decoded a legal instruction
//   imem_error_i   fetch address fault
//   dmem_error_i   data memory fault, qualified by mem_ready_i
//   mem_ready_i    data memory access complete
//   nextpc_i       next PC from the update stage
//   bp_en_i        (optional) breakpoint enable
//   bp_addr_i      (optional) breakpoint PC
//   bp_hit_o       (optional) stopped on breakpoint
//   pc_o           current PC
//   fetch_en_o .. pc_we_o  one-hot registered stage enables
//   stat_o         1=AOK 2=HLT 3=ADR 4=INS
//   halted_o       FSM is in HALT
//   retired_o      one-cycle pulse after an instruction commits
//   instr_cnt_o    retired-instruction count (saturating)
//   cycle_cnt_o    cycles spent in FETCH..PCUPD (saturating)
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for run_i or step_i
// FETCH  | fetch stage enabled; fetch faults and halt decoded here
// DECODE | decode stage enabled
// EXEC   | execute stage enabled
// MEM    | memory stage enabled; waits for mem_ready_i with timeout
// WB     | register writeback enabled
// PCUPD  | PC write; instruction commits on the exit edge
// HALT   | sticky stop with status code; only reset leaves
// -----------------------------------------------------------------------------
module y86_seq_ctrl #(
  parameter int unsigned     PC_W        = 64,
  parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
  parameter int unsigned     CNT_W       = 32,
  parameter int unsigned     MEM_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [3:0]       icode_i,
  input  logic             instr_valid_i,
  input  logic             imem_error_i,
  input  logic             dmem_error_i,
  input  logic             mem_ready_i,
  input  logic [PC_W-1:0]  nextpc_i,
`ifdef Y86_SEQ_CTRL_BRKPT_EN
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  output logic             bp_hit_o,
`endif
  output logic [PC_W-1:0]  pc_o,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             exec_en_o,
  output logic             mem_en_o,
  output logic             wb_en_o,
  output logic             pc_we_o,
  output logic [3:0]       stat_o,
  output logic             halted_o,
  output logic             retired_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PCUPD  = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_HLT = 4'd2;
  localparam logic [3:0] STAT_ADR = 4'd3;
  localparam logic [3:0] STAT_INS = 4'd4;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  // MEM wait is a down-counter; the terminal count (zero) on a not-ready
  // cycle is the MEM_TIMEOUT-th wait cycle.
  localparam logic [7:0]       WAIT_LOAD = 8'(MEM_TIMEOUT - 1);

  state_e           state_q;
  logic [5:0]       en_q;        // {fetch, decode, exec, mem, wb, pc_we}
  logic [PC_W-1:0]  pc_q;
  logic [3:0]       stat_q;
  logic             halted_q;
  logic             retired_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic             step_flag_q;
  logic [7:0]       wait_q;
`ifdef Y86_SEQ_CTRL_BRKPT_EN
  logic             bp_hit_q;
  logic             run_q;
  logic             run_rise;
  assign run_rise = run_i & ~run_q;
`endif

  // Enable pattern for the state being entered, so enables are registered
  // alongside the state and line up with it exactly.
  function automatic logic [5:0] en_of(input state_e s);
    logic [5:0] e;
    e = 6'b000000;
    case (s)
      S_FETCH:  e = 6'b100000;
      S_DECODE: e = 6'b010000;
      S_EXEC:   e = 6'b001000;
      S_MEM:    e = 6'b000100;
      S_WB:     e = 6'b000010;
      S_PCUPD:  e = 6'b000001;
      default:  e = 6'b000000;
    endcase
    return e;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q     <= S_IDLE;
      en_q        <= 6'b000000;
      pc_q        <= RESET_PC;
      stat_q      <= STAT_AOK;
      halted_q    <= 1'b0;
      retired_q   <= 1'b0;
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
      step_flag_q <= 1'b0;
      wait_q      <= 8'd0;
`ifdef Y86_SEQ_CTRL_BRKPT_EN
      bp_hit_q    <= 1'b0;
      run_q       <= 1'b0;
`endif
    end else begin
      retired_q <= 1'b0;
`ifdef Y86_SEQ_CTRL_BRKPT_EN
      run_q     <= run_i;
`endif

      if (state_q != S_IDLE && state_q != S_HALT && cycle_cnt_q != CNT_MAX)
        cycle_cnt_q <= cycle_cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
`ifdef Y86_SEQ_CTRL_BRKPT_EN
          if (bp_hit_q && (step_i || run_rise)) begin
            // Resume onto the breakpointed PC without re-checking it.
            bp_hit_q    <= 1'b0;
            state_q     <= S_FETCH;
            en_q        <= en_of(S_FETCH);
            step_flag_q <= ~run_i;
          end else if (run_i || step_i) begin
            if (bp_en_i && (pc_q == bp_addr_i)) begin
              bp_hit_q <= 1'b1;
            end else begin
              state_q     <= S_FETCH;
              en_q        <= en_of(S_FETCH);
              step_flag_q <= ~run_i;
            end
          end
`else
          if (run_i || step_i) begin
            state_q     <= S_FETCH;
            en_q        <= en_of(S_FETCH);
            step_flag_q <= ~run_i;
          end
`endif
        end

        S_FETCH: begin
          if (imem_error_i) begin
            state_q  <= S_HALT;
            en_q     <= en_of(S_HALT);
            stat_q   <= STAT_ADR;
            halted_q <= 1'b1;
          end else if (!instr_valid_i) begin
            state_q  <= S_HALT;
            en_q     <= en_of(S_HALT);
            stat_q   <= STAT_INS;
            halted_q <= 1'b1;
          end else if (icode_i == 4'h0) begin
            state_q  <= S_HALT;
            en_q     <= en_of(S_HALT);
            stat_q   <= STAT_HLT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_DECODE;
            en_q    <= en_of(S_DECODE);
          end
        end

        S_DECODE: begin
          state_q <= S_EXEC;
          en_q    <= en_of(S_EXEC);
        end

        S_EXEC: begin
          state_q <= S_MEM;
          en_q    <= en_of(S_MEM);
          wait_q  <= WAIT_LOAD;
        end

        S_MEM: begin
          // dmem_error_i only means something once the access completes.
          if (mem_ready_i) begin
            if (dmem_error_i) begin
              state_q  <= S_HALT;
              en_q     <= en_of(S_HALT);
              stat_q   <= STAT_ADR;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_WB;
              en_q    <= en_of(S_WB);
            end
          end else if (wait_q == 8'd0) begin
            state_q  <= S_HALT;
            en_q     <= en_of(S_HALT);
            stat_q   <= STAT_ADR;
            halted_q <= 1'b1;
          end else begin
            wait_q <= wait_q - 8'd1;
          end
        end

        S_WB: begin
          state_q <= S_PCUPD;
          en_q    <= en_of(S_PCUPD);
        end

        S_PCUPD: begin
          pc_q        <= nextpc_i;
          retired_q   <= 1'b1;
          step_flag_q <= 1'b0;
          if (instr_cnt_q != CNT_MAX)
            instr_cnt_q <= instr_cnt_q + 1'b1;
          if (run_i && !step_flag_q) begin
`ifdef Y86_SEQ_CTRL_BRKPT_EN
            if (bp_en_i && (nextpc_i == bp_addr_i)) begin
              state_q  <= S_IDLE;
              en_q     <= en_of(S_IDLE);
              bp_hit_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              en_q    <= en_of(S_FETCH);
            end
`else
            state_q <= S_FETCH;
            en_q    <= en_of(S_FETCH);
`endif
          end else begin
            state_q <= S_IDLE;
            en_q    <= en_of(S_IDLE);
          end
        end

        S_HALT: begin
          state_q <= S_HALT;
          en_q    <= en_of(S_HALT);
        end

        default: begin
          state_q <= S_IDLE;
          en_q    <= en_of(S_IDLE);
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign fetch_en_o  = en_q[5];
  assign decode_en_o = en_q[4];
  assign exec_en_o   = en_q[3];
  assign mem_en_o    = en_q[2];
  assign wb_en_o     = en_q[1];
  assign pc_we_o     = en_q[0];
  assign stat_o      = stat_q;
  assign halted_o    = halted_q;
  assign retired_o   = retired_q;
  assign instr_cnt_o = instr_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;
`ifdef Y86_SEQ_CTRL_BRKPT_EN
  assign bp_hit_o    = bp_hit_q;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed bench for y86_seq_ctrl. A second instance with 4-bit counters
// shares all inputs so counter saturation is reachable in a short run.
module tb_y86_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step;
  logic [3:0]  icode;
  logic        valid;
  logic        imem_err;
  logic        dmem_err;
  logic        ready;
  logic [63:0] nextpc;

  logic [63:0] pc;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we;
  logic [3:0]  stat;
  logic        halted, retired;
  logic [31:0] instr_cnt, cycle_cnt;

  logic [63:0] s_pc;
  logic        s_fetch_en, s_decode_en, s_exec_en, s_mem_en, s_wb_en, s_pc_we;
  logic [3:0]  s_stat;
  logic        s_halted, s_retired;
  logic [3:0]  s_instr_cnt, s_cycle_cnt;

`ifdef Y86_SEQ_CTRL_BRKPT_EN
  logic        bp_en;
  logic [63:0] bp_addr;
  logic        bp_hit, s_bp_hit;
`endif

  logic [5:0] en;
  assign en = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_we};

  // Update stage stand-in: every instruction is one byte long.
  assign nextpc = pc + 64'd1;

  int vectors     = 0;
  int miscompares = 0;

  y86_seq_ctrl dut (
    .clk_i(clk), .rst_n_i(rst), .run_i(run), .step_i(step),
    .icode_i(icode), .instr_valid_i(valid), .imem_error_i(imem_err),
    .dmem_error_i(dmem_err), .mem_ready_i(ready), .nextpc_i(nextpc),
`ifdef Y86_SEQ_CTRL_BRKPT_EN
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .bp_hit_o(bp_hit),
`endif
    .pc_o(pc), .fetch_en_o(fetch_en), .decode_en_o(decode_en),
    .exec_en_o(exec_en), .mem_en_o(mem_en), .wb_en_o(wb_en), .pc_we_o(pc_we),
    .stat_o(stat), .halted_o(halted), .retired_o(retired),
    .instr_cnt_o(instr_cnt), .cycle_cnt_o(cycle_cnt)
  );

  y86_seq_ctrl #(.CNT_W(4)) dut_s (
    .clk_i(clk), .rst_n_i(rst), .run_i(run), .step_i(step),
    .icode_i(icode), .instr_valid_i(valid), .imem_error_i(imem_err),
    .dmem_error_i(dmem_err), .mem_ready_i(ready), .nextpc_i(nextpc),
`ifdef Y86_SEQ_CTRL_BRKPT_EN
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .bp_hit_o(s_bp_hit),
`endif
    .pc_o(s_pc), .fetch_en_o(s_fetch_en), .decode_en_o(s_decode_en),
    .exec_en_o(s_exec_en), .mem_en_o(s_mem_en), .wb_en_o(s_wb_en), .pc_we_o(s_pc_we),
    .stat_o(s_stat), .halted_o(s_halted), .retired_o(s_retired),
    .instr_cnt_o(s_instr_cnt), .cycle_cnt_o(s_cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},      {58'd0, en}, 64'd0);
    chk({tag, "_pc"},      pc, 64'd0);
    chk({tag, "_stat"},    {60'd0, stat}, 64'd1);
    chk({tag, "_halted"},  {63'd0, halted}, 64'd0);
    chk({tag, "_retired"}, {63'd0, retired}, 64'd0);
    chk({tag, "_icnt"},    {32'd0, instr_cnt}, 64'd0);
    chk({tag, "_ccnt"},    {32'd0, cycle_cnt}, 64'd0);
    chk({tag, "_s_icnt"},  {60'd0, s_instr_cnt}, 64'd0);
  endtask

  task automatic step_nop();
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (7) tick();
  endtask

  logic [5:0] seq [6] = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};
  logic [3:0] f_icode [3] = '{4'h0, 4'h1, 4'h1};
  logic       f_valid [3] = '{1'b1, 1'b0, 1'b0};
  logic       f_imem  [3] = '{1'b0, 1'b0, 1'b1};
  logic [3:0] f_stat  [3] = '{4'd2, 4'd4, 4'd3};

  initial begin
    int rcnt;
    int mcnt;
    int wcnt;
    rst = 1'b1; run = 1'b0; step = 1'b0;
    icode = 4'h1; valid = 1'b1; imem_err = 1'b0; dmem_err = 1'b0; ready = 1'b1;
`ifdef Y86_SEQ_CTRL_BRKPT_EN
    bp_en = 1'b0; bp_addr = 64'd0;
`endif

    // Reset state
    tick();
    chk_reset("rst0");
    rst = 1'b0;

    // Free-run nops: one enable per cycle in stage order
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("run_en_seq", {58'd0, en}, {58'd0, seq[i]});
    end
    tick();
    chk("run_pc1", pc, 64'd1);
    chk("run_ret1", {63'd0, retired}, 64'd1);
    chk("run_icnt1", {32'd0, instr_cnt}, 64'd1);
    chk("run_en_f2", {58'd0, en}, 64'h20);
    repeat (12) tick();
    chk("run_icnt3", {32'd0, instr_cnt}, 64'd3);
    chk("run_ccnt18", {32'd0, cycle_cnt}, 64'd18);
    chk("run_pc3", pc, 64'd3);

    // Drop run mid-instruction: it completes, then IDLE
    run = 1'b0;
    repeat (6) tick();
    chk("drop_en", {58'd0, en}, 64'd0);
    chk("drop_pc", pc, 64'd4);
    chk("drop_icnt", {32'd0, instr_cnt}, 64'd4);
    chk("drop_ret", {63'd0, retired}, 64'd1);
    chk("drop_ccnt", {32'd0, cycle_cnt}, 64'd24);
    tick();
    chk("drop_ret_low", {63'd0, retired}, 64'd0);
    chk("drop_idle", {58'd0, en}, 64'd0);

    // Single step
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_fetch", {58'd0, en}, 64'h20);
    rcnt = 0;
    repeat (10) begin
      tick();
      if (retired) rcnt++;
    end
    chk("step_retires", 64'(rcnt), 64'd1);
    chk("step_idle", {58'd0, en}, 64'd0);
    chk("step_pc", pc, 64'd5);
    chk("step_icnt", {32'd0, instr_cnt}, 64'd5);
    chk("step_ccnt", {32'd0, cycle_cnt}, 64'd30);

    // MEM wait: ready low for 3 MEM cycles, high on the 4th
    ready = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    mcnt = 0; rcnt = 0;
    repeat (14) begin
      tick();
      if (mem_en) begin
        mcnt++;
        if (mcnt == 4) ready = 1'b1;
      end
      if (retired) rcnt++;
    end
    chk("memw_cycles", 64'(mcnt), 64'd4);
    chk("memw_retires", 64'(rcnt), 64'd1);
    chk("memw_pc", pc, 64'd6);
    chk("memw_ccnt", {32'd0, cycle_cnt}, 64'd39);
    chk("memw_stat", {60'd0, stat}, 64'd1);

    // Long run: 13 more instructions; 4-bit counters saturate
    run = 1'b1;
    tick();
    repeat (72) tick();
    run = 1'b0;
    repeat (8) tick();
    chk("long_icnt", {32'd0, instr_cnt}, 64'd19);
    chk("long_ccnt", {32'd0, cycle_cnt}, 64'd117);
    chk("long_pc", pc, 64'd19);
    chk("sat_icnt", {60'd0, s_instr_cnt}, 64'hf);
    chk("sat_ccnt", {60'd0, s_cycle_cnt}, 64'hf);
    chk("sat_pc", s_pc, 64'd19);

    // Reset while in EXEC
    run = 1'b1;
    tick(); tick(); tick();
    chk("mid_exec", {58'd0, en}, 64'h08);
    rst = 1'b1;
    run = 1'b0;
    tick();
    chk_reset("rst_exec");
    rst = 1'b0;

    // Fetch faults at PC=1: halt, INS, ADR-priority
    for (int k = 0; k < 3; k++) begin
      step_nop();
      chk("flt_pre_pc", pc, 64'd1);
      icode = f_icode[k]; valid = f_valid[k]; imem_err = f_imem[k];
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      chk("flt_stat", {60'd0, stat}, {60'd0, f_stat[k]});
      chk("flt_halted", {63'd0, halted}, 64'd1);
      chk("flt_en", {58'd0, en}, 64'd0);
      chk("flt_pc", pc, 64'd1);
      chk("flt_icnt", {32'd0, instr_cnt}, 64'd1);
      run = 1'b1;
      repeat (3) tick();
      run = 1'b0;
      chk("flt_sticky", {63'd0, halted}, 64'd1);
      chk("flt_stat_hold", {60'd0, stat}, {60'd0, f_stat[k]});
      chk("flt_ccnt_frozen", {32'd0, cycle_cnt}, 64'd7);
      chk("flt_noret", {63'd0, retired}, 64'd0);
      icode = 4'h1; valid = 1'b1; imem_err = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    // MEM timeout; dmem_error ignored while not ready
    ready = 1'b0;
    dmem_err = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    mcnt = 0; wcnt = 0;
    repeat (24) begin
      tick();
      if (mem_en) mcnt++;
      if (wb_en) wcnt++;
    end
    chk("tmo_mem_cycles", 64'(mcnt), 64'd16);
    chk("tmo_no_wb", 64'(wcnt), 64'd0);
    chk("tmo_stat", {60'd0, stat}, 64'd3);
    chk("tmo_halted", {63'd0, halted}, 64'd1);
    chk("tmo_icnt", {32'd0, instr_cnt}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // dmem_error with ready: immediate ADR
    ready = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    mcnt = 0; wcnt = 0;
    repeat (10) begin
      tick();
      if (mem_en) mcnt++;
      if (wb_en) wcnt++;
    end
    chk("derr_mem_cycles", 64'(mcnt), 64'd1);
    chk("derr_no_wb", 64'(wcnt), 64'd0);
    chk("derr_stat", {60'd0, stat}, 64'd3);
    chk("derr_pc", pc, 64'd0);
    dmem_err = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

`ifdef Y86_SEQ_CTRL_BRKPT_EN
    // Breakpoint at PC=2
    bp_en = 1'b1;
    bp_addr = 64'd2;
    run = 1'b1;
    repeat (20) tick();
    chk("bp_stop_en", {58'd0, en}, 64'd0);
    chk("bp_stop_pc", pc, 64'd2);
    chk("bp_hit_set", {63'd0, bp_hit}, 64'd1);
    chk("bp_stop_icnt", {32'd0, instr_cnt}, 64'd2);
    run = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("bp_hit_clr", {63'd0, bp_hit}, 64'd0);
    chk("bp_resume_f", {58'd0, en}, 64'h20);
    repeat (7) tick();
    chk("bp_step_pc", pc, 64'd3);
    chk("bp_step_icnt", {32'd0, instr_cnt}, 64'd3);
    chk("bp_step_idle", {58'd0, en}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
